// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared symbols and state encoding for the phy receive lanes
package phy_pkg;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam logic [7:0] IDLE  = 8'h7C;

  localparam int BIT_CNT_W = 3;
  localparam int BC_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } rx_state_t;

  function automatic logic is_fill(input logic [7:0] b);
    return (b == COMMA) || (b == IDLE);
  endfunction

endpackage

// File: rtl/phy_rx_lane.sv
// rtl/phy_rx_lane.sv - serial-to-parallel lane receiver with comma alignment
// Slides bit-by-bit until a COMMA, then counts aligned commas to lock and delivers data bytes.
module phy_rx_lane
  import phy_pkg::*;
#(
  parameter int BC_NEEDED = 4
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [BC_CNT_W:0] BC_TARGET = (BC_CNT_W+1)'(BC_NEEDED);

  rx_state_t              r_state;
  logic [7:0]             r_sr;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [BC_CNT_W-1:0]    r_bc_cnt;
  logic [7:0]             r_data_out;
  logic                   r_valid_out;
  logic                   r_active;

  rx_state_t              w_state_nxt;
  logic [7:0]             w_nxt;
  logic                   w_boundary;
  logic                   w_is_comma;
  logic [BIT_CNT_W-1:0]   w_bit_cnt_nxt;
  logic [BC_CNT_W-1:0]    w_bc_cnt_nxt;
  logic [BC_CNT_W-1:0]    w_bc_cnt_inc;
  logic [7:0]             w_data_out_nxt;
  logic                   w_valid_out_nxt;
  logic                   w_active_nxt;

  // Every decision looks at the byte including the bit sampled this edge.
  assign w_nxt        = {r_sr[6:0], data_in};
  assign w_boundary   = (r_bit_cnt == 3'd7);
  assign w_is_comma   = (w_nxt == COMMA);
  assign w_bc_cnt_inc = (r_bc_cnt == {BC_CNT_W{1'b1}}) ? r_bc_cnt : r_bc_cnt + 4'd1;

  always_ff @(posedge clk_8f) begin
    if (!reset_L) begin
      r_state     <= ST_SEARCH;
      r_sr        <= 8'h00;
      r_bit_cnt   <= '0;
      r_bc_cnt    <= '0;
      r_data_out  <= 8'h00;
      r_valid_out <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_bc_cnt    <= w_bc_cnt_nxt;
      r_data_out  <= w_data_out_nxt;
      r_valid_out <= w_valid_out_nxt;
      r_active    <= w_active_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
    w_bc_cnt_nxt  = r_bc_cnt;
    case (r_state)
      ST_SEARCH: begin
        // Bit position is meaningless while sliding; the comma defines it.
        w_bit_cnt_nxt = '0;
        if (w_is_comma) begin
          w_bc_cnt_nxt = 4'd1;
          w_state_nxt  = (BC_NEEDED == 1) ? ST_ACTIVE : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (w_boundary) begin
          if (w_is_comma) begin
            w_bc_cnt_nxt = w_bc_cnt_inc;
            if (({1'b0, r_bc_cnt} + 5'd1) == BC_TARGET) begin
              w_state_nxt = ST_ACTIVE;
            end
          end else begin
            w_bc_cnt_nxt = '0;
            w_state_nxt  = ST_SEARCH;
          end
        end
      end
      ST_ACTIVE: begin
        w_state_nxt = ST_ACTIVE;
      end
      default: begin
        w_state_nxt = ST_SEARCH;
      end
    endcase
  end

  always_comb begin
    w_data_out_nxt  = r_data_out;
    w_valid_out_nxt = 1'b0;
    w_active_nxt    = r_active;
    if (w_state_nxt == ST_ACTIVE) begin
      w_active_nxt = 1'b1;
    end
    // Fill symbols are swallowed so data_out keeps the last real byte.
    if ((r_state == ST_ACTIVE) && w_boundary && !is_fill(w_nxt)) begin
      w_data_out_nxt  = w_nxt;
      w_valid_out_nxt = 1'b1;
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign active    = r_active;

endmodule

// File: tb/tb_phy_rx_lane.sv
// tb/tb_phy_rx_lane.sv - scoreboard bench for phy_rx_lane
module tb_phy_rx_lane;

  logic       clk_8f;
  logic       reset_L;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_checks;
  int n_fail;
  int cyc;
  logic prev_valid;
  logic [7:0] exp_q[$];
  int pulse_cyc[$];

  phy_rx_lane #(.BC_NEEDED(4)) dut (
    .clk_8f   (clk_8f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  initial begin
    clk_8f = 1'b0;
    forever #5 clk_8f = ~clk_8f;
  end

  always @(posedge clk_8f) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected byte per valid_out pulse.
  always @(negedge clk_8f) begin
    if (valid_out === 1'b1) begin
      pulse_cyc.push_back(cyc);
      check("valid_while_active", {7'd0, active}, 8'h01);
      check("valid_not_back_to_back", {7'd0, prev_valid}, 8'h00);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_pulse: got %h expected no pulse", data_out);
      end else begin
        check("data_out", data_out, exp_q.pop_front());
      end
    end
    prev_valid = valid_out;
  end

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_data(input logic [7:0] v);
    exp_q.push_back(v);
    send_byte(v);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    data_in = 1'b0;
    repeat (2) @(posedge clk_8f);
    #1;
    reset_L = 1'b1;
  endtask

  task automatic lock4(input string name);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'hBC);
      check(name, {7'd0, active}, 8'h00);
    end
    send_byte(8'hBC);
    check(name, {7'd0, active}, 8'h01);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    prev_valid = 1'b0;
    reset_L = 1'b0;
    data_in = 1'b0;

    // Reset hold with random serial input.
    @(posedge clk_8f);
    #1;
    for (int k = 0; k < 4; k++) begin
      data_in = 1'($urandom);
      @(posedge clk_8f);
      #1;
      check("rst_data_out", data_out, 8'h00);
      check("rst_valid_out", {7'd0, valid_out}, 8'h00);
      check("rst_active", {7'd0, active}, 8'h00);
    end
    reset_L = 1'b1;
    lock4("lock_after_reset");

    // Misaligned start then two data bytes eight cycles apart.
    do_reset();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    lock4("lock_misaligned");
    send_data(8'hA5);
    send_data(8'h3C);
    send_byte(8'h7C);
    if (pulse_cyc.size() < 2) begin
      n_checks++;
      n_fail++;
      $display("FAIL pulse_spacing: got %0d pulses expected 2", pulse_cyc.size());
    end else begin
      check("pulse_spacing", 8'(pulse_cyc[$] - pulse_cyc[$-1]), 8'd8);
    end

    // Broken lock falls back to search and needs four fresh commas.
    do_reset();
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h12);
    check("broken_active", {7'd0, active}, 8'h00);
    lock4("lock_after_break");

    // Fill filtering while active.
    send_data(8'h01);
    send_byte(8'h7C);
    check("hold_after_idle", data_out, 8'h01);
    send_byte(8'hBC);
    check("hold_after_comma", data_out, 8'h01);
    send_data(8'hFF);
    send_byte(8'h7C);
    check("data_before_midreset", data_out, 8'hFF);

    // Reset at bit 4 of a data byte while active.
    for (int i = 7; i >= 4; i--) send_bit(1'b1);
    reset_L = 1'b0;
    send_bit(1'b0);
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_valid_out", {7'd0, valid_out}, 8'h00);
    check("midrst_active", {7'd0, active}, 8'h00);
    reset_L = 1'b1;
    lock4("lock_after_midreset");

    // Byte sequence 00..0F with occasional fill in between.
    for (int v = 0; v < 16; v++) begin
      send_data(8'(v));
      if (v % 5 == 2) send_byte(8'h7C);
    end
    send_byte(8'hBC);
    send_byte(8'hBC);

    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
